// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: follows an upstream one-hot ring, inserts dead time
// between digits, double-buffers BCD data at frame boundaries and blanks leading zeros.
//
// state | meaning
// IDLE  | no frame loaded yet; display dark until first pending->display copy
// BLANK | dead time after a digit switch (or while ring_i is invalid)
// SHOW  | current digit driven from the display register
module seg7_scan #(
  parameter int num_digits_p   = 4,
  parameter int blank_cycles_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [num_digits_p-1:0]   ring_i,
  input  logic [4*num_digits_p-1:0] bcd_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      lzb_en_i,
  output logic [6:0]                seg_o,
  output logic [num_digits_p-1:0]   dig_o,
  output logic                      frame_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  localparam logic [7:0] blank_load_lp = 8'(blank_cycles_p);

  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [num_digits_p-1:0]     ring_q;
  logic [4*num_digits_p-1:0]   pend_q, disp_q;
  logic                        pend_full_q;
  logic                        err_q;
  logic                        frame_q;
  logic [6:0]                  seg_q, seg_d;
  logic [num_digits_p-1:0]     dig_q, dig_d;

  logic                        change, ring_ok, frame_bound, load_disp, accept;
  logic [3:0]                  sel_nib;
  logic                        sel_blank;
  logic                        all_zero;
  logic [num_digits_p-1:0]     blank_mask;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  assign change      = (ring_i != ring_q);
  assign ring_ok     = $onehot(ring_i);
  assign frame_bound = change && ring_i[0] && ring_ok;
  assign load_disp   = frame_bound && pend_full_q;
  assign accept      = valid_i && !pend_full_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!ring_ok) begin
      state_d = BLANK;
      cnt_d   = blank_load_lp;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_disp) begin
            state_d = BLANK;
            cnt_d   = blank_load_lp;
          end
        end
        BLANK: begin
          if (change) begin
            cnt_d = blank_load_lp;
          end else if (cnt_q == 8'd0) begin
            state_d = SHOW;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        SHOW: begin
          if (change) begin
            state_d = BLANK;
            cnt_d   = blank_load_lp;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      endcase
    end
  end

  // Leading-zero mask scans from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    all_zero   = 1'b1;
    blank_mask = '0;
    sel_nib    = 4'd0;
    sel_blank  = 1'b0;
    for (int i = num_digits_p - 1; i >= 1; i--) begin
      all_zero      = all_zero & (disp_q[4*i +: 4] == 4'd0);
      blank_mask[i] = lzb_en_i & all_zero;
    end
    for (int i = 0; i < num_digits_p; i++) begin
      if (ring_q[i]) begin
        sel_nib   = disp_q[4*i +: 4];
        sel_blank = blank_mask[i];
      end
    end
  end

  // SHOW is only entered or held while ring_i == ring_q, so ring_q is the digit on the next cycle.
  always_comb begin
    seg_d = 7'h00;
    dig_d = '0;
    if (state_d == SHOW) begin
      dig_d = ring_q;
      if (!sel_blank) seg_d = seg_decode(sel_nib);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      ring_q  <= '0;
      seg_q   <= 7'h00;
      dig_q   <= '0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ring_q  <= ring_i;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= load_disp;
      err_q   <= err_q | !ring_ok;
    end
  end

  // A copy and an accept never coincide: the copy needs pending full, which holds ready low.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pend_q      <= '0;
      disp_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (load_disp) begin
      disp_q      <= pend_q;
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pend_q      <= bcd_i;
      pend_full_q <= 1'b1;
    end
  end

  assign ready_o = !pend_full_q;
  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: frame loading, dead time, decode, leading-zero
// blanking, back-pressure, ring error handling and asynchronous reset.
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [3:0]  ring_i;
  logic [15:0] bcd_i;
  logic        valid_i;
  logic        ready_o;
  logic        lzb_en_i;
  logic [6:0]  seg_o;
  logic [3:0]  dig_o;
  logic        frame_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;

  logic [6:0] exp_1234 [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};

  always #5 clk = ~clk;

  seg7_scan #(.num_digits_p(4), .blank_cycles_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .ring_i(ring_i), .bcd_i(bcd_i),
    .valid_i(valid_i), .ready_o(ready_o), .lzb_en_i(lzb_en_i),
    .seg_o(seg_o), .dig_o(dig_o), .frame_o(frame_o), .err_o(err_o)
  );

  always @(negedge clk) if (frame_o === 1'b1) frame_cnt++;

  // Select digit idx, then observe 20 cycles; reports dark cycles and final outputs.
  task automatic run_digit(input int idx, output int nblank, output logic [6:0] s, output logic [3:0] d);
    ring_i = 4'(1 << idx);
    nblank = 0;
    repeat (20) begin
      @(negedge clk);
      if (dig_o == 4'b0000) nblank++;
    end
    s = seg_o;
    d = dig_o;
  endtask

  task automatic test_reset;
    reset_i = 1'b0; ring_i = 4'b0001; bcd_i = '0; valid_i = 1'b0; lzb_en_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dig_o !== 4'h0 || seg_o !== 7'h00) begin errors++; $display("FAIL reset_out dig %h seg %h exp 0 0", dig_o, seg_o); end
    checks++; if (frame_o !== 1'b0 || err_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL reset_flags frame %b err %b ready %b exp 0 0 1", frame_o, err_o, ready_o); end
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (err_o !== 1'b0 || dig_o !== 4'h0 || frame_cnt !== 0) begin errors++; $display("FAIL post_reset err %b dig %h frames %0d exp 0 0 0", err_o, dig_o, frame_cnt); end
  endtask

  task automatic test_basic;
    int nb; logic [6:0] s; logic [3:0] d;
    frame_cnt = 0;
    bcd_i = 16'h1234; valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL basic_accept ready %b exp 0", ready_o); end
    for (int i = 1; i < 4; i++) begin
      run_digit(i, nb, s, d);
      checks++; if (d !== 4'h0 || frame_cnt !== 0) begin errors++; $display("FAIL basic_idle%0d dig %h frames %0d exp 0 0", i, d, frame_cnt); end
    end
    for (int i = 0; i < 4; i++) begin
      run_digit(i, nb, s, d);
      checks++; if (nb !== 9) begin errors++; $display("FAIL basic_blank%0d got %0d exp 9", i, nb); end
      checks++; if (d !== 4'(1 << i) || s !== exp_1234[i]) begin errors++; $display("FAIL basic_digit%0d dig %h seg %h exp %h %h", i, d, s, 4'(1 << i), exp_1234[i]); end
    end
    checks++; if (frame_cnt !== 1 || ready_o !== 1'b1) begin errors++; $display("FAIL basic_frame frames %0d ready %b exp 1 1", frame_cnt, ready_o); end
    run_digit(0, nb, s, d);
    checks++; if (frame_cnt !== 1 || s !== 7'h66) begin errors++; $display("FAIL basic_noload frames %0d seg %h exp 1 66", frame_cnt, s); end
  endtask

  task automatic test_lzb;
    int nb; logic [6:0] s; logic [3:0] d;
    lzb_en_i = 1'b1; bcd_i = 16'h0070; valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    for (int i = 1; i < 4; i++) run_digit(i, nb, s, d);
    run_digit(0, nb, s, d);
    checks++; if (s !== 7'h3F || d !== 4'b0001) begin errors++; $display("FAIL lzb_d0 seg %h dig %h exp 3f 1", s, d); end
    run_digit(1, nb, s, d);
    checks++; if (s !== 7'h07 || d !== 4'b0010) begin errors++; $display("FAIL lzb_d1 seg %h dig %h exp 07 2", s, d); end
    run_digit(2, nb, s, d);
    checks++; if (s !== 7'h00 || d !== 4'b0100) begin errors++; $display("FAIL lzb_d2 seg %h dig %h exp 00 4", s, d); end
    run_digit(3, nb, s, d);
    checks++; if (s !== 7'h00 || d !== 4'b1000) begin errors++; $display("FAIL lzb_d3 seg %h dig %h exp 00 8", s, d); end
    lzb_en_i = 1'b0;
  endtask

  task automatic test_back_to_back;
    int nb; logic [6:0] s; logic [3:0] d;
    frame_cnt = 0;
    bcd_i = 16'h1111; valid_i = 1'b1;
    @(negedge clk);
    checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_first ready %b exp 0", ready_o); end
    bcd_i = 16'h2222;
    for (int i = 1; i < 4; i++) begin
      run_digit(i, nb, s, d);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL hold_stall%0d ready %b exp 0", i, ready_o); end
    end
    run_digit(0, nb, s, d);
    valid_i = 1'b0;
    checks++; if (s !== 7'h06 || frame_cnt !== 1 || ready_o !== 1'b0) begin errors++; $display("FAIL hold_frame1 seg %h frames %0d ready %b exp 06 1 0", s, frame_cnt, ready_o); end
    for (int i = 1; i < 4; i++) begin
      run_digit(i, nb, s, d);
      checks++; if (s !== 7'h06) begin errors++; $display("FAIL hold_tear%0d seg %h exp 06", i, s); end
    end
    run_digit(0, nb, s, d);
    checks++; if (s !== 7'h5B || frame_cnt !== 2 || ready_o !== 1'b1) begin errors++; $display("FAIL hold_frame2 seg %h frames %0d ready %b exp 5b 2 1", s, frame_cnt, ready_o); end
  endtask

  task automatic test_dash;
    int nb; logic [6:0] s; logic [3:0] d;
    bcd_i = 16'h000A; valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    for (int i = 1; i < 4; i++) run_digit(i, nb, s, d);
    run_digit(0, nb, s, d);
    checks++; if (s !== 7'h40 || d !== 4'b0001) begin errors++; $display("FAIL dash_d0 seg %h dig %h exp 40 1", s, d); end
    run_digit(1, nb, s, d);
    checks++; if (s !== 7'h3F) begin errors++; $display("FAIL dash_d1 seg %h exp 3f", s); end
  endtask

  task automatic test_err;
    int bad;
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before got %b exp 0", err_o); end
    ring_i = 4'b0110;
    @(negedge clk);
    checks++; if (err_o !== 1'b1 || dig_o !== 4'h0) begin errors++; $display("FAIL err_set err %b dig %h exp 1 0", err_o, dig_o); end
    ring_i = 4'b0100;
    repeat (5) @(negedge clk);
    checks++; if (err_o !== 1'b1 || dig_o !== 4'h0) begin errors++; $display("FAIL err_sticky err %b dig %h exp 1 0", err_o, dig_o); end
    repeat (10) @(negedge clk);
    checks++; if (dig_o !== 4'b0100 || seg_o !== 7'h3F) begin errors++; $display("FAIL err_recover dig %h seg %h exp 4 3f", dig_o, seg_o); end
    ring_i = 4'b0000;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (dig_o !== 4'h0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL err_zero_ring lit_cycles %0d exp 0", bad); end
    ring_i = 4'b0001;
    repeat (15) @(negedge clk);
    checks++; if (dig_o !== 4'b0001 || seg_o !== 7'h40 || err_o !== 1'b1) begin errors++; $display("FAIL err_after dig %h seg %h err %b exp 1 40 1", dig_o, seg_o, err_o); end
  endtask

  task automatic test_reset_mid;
    int nb; logic [6:0] s; logic [3:0] d;
    bcd_i = 16'h5678; valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    checks++; if (ready_o !== 1'b0 || dig_o !== 4'b0001) begin errors++; $display("FAIL rst_pre ready %b dig %h exp 0 1", ready_o, dig_o); end
    #2 reset_i = 1'b0;
    #1;
    checks++; if (dig_o !== 4'h0 || seg_o !== 7'h00 || ready_o !== 1'b1) begin errors++; $display("FAIL rst_async dig %h seg %h ready %b exp 0 0 1", dig_o, seg_o, ready_o); end
    checks++; if (err_o !== 1'b0 || frame_o !== 1'b0) begin errors++; $display("FAIL rst_flags err %b frame %b exp 0 0", err_o, frame_o); end
    @(negedge clk); reset_i = 1'b1;
    run_digit(1, nb, s, d);
    checks++; if (d !== 4'h0 || err_o !== 1'b0 || ready_o !== 1'b1) begin errors++; $display("FAIL rst_idle dig %h err %b ready %b exp 0 0 1", d, err_o, ready_o); end
    frame_cnt = 0;
    bcd_i = 16'h0009; valid_i = 1'b1;
    @(negedge clk); valid_i = 1'b0;
    run_digit(2, nb, s, d);
    run_digit(3, nb, s, d);
    run_digit(0, nb, s, d);
    checks++; if (s !== 7'h6F || d !== 4'b0001 || frame_cnt !== 1) begin errors++; $display("FAIL rst_reload seg %h dig %h frames %0d exp 6f 1 1", s, d, frame_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_lzb;
    test_back_to_back;
    test_dash;
    test_err;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
